// File: rtl/tpuv2.sv
// Memory-mapped DIMxDIM signed matrix-multiply tile: A, B and C register files behind a
// word bus; a job computes one C row per cycle into a shadow buffer and commits it at the end.
module tpuv2 #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8,
    parameter int ADDRW   = 16,
    parameter int DATAW   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             r_w,
    input  logic [ADDRW-1:0] addr,
    input  logic [DATAW-1:0] dataIn,
    output logic [DATAW-1:0] dataOut,
    output logic             rvalid,
    output logic             irq
);

    localparam int WA   = DIM * BITS_AB / DATAW;
    localparam int WC   = DIM * BITS_C / DATAW;
    localparam int RA   = DIM * BITS_AB;
    localparam int RC   = DIM * BITS_C;
    localparam int PW   = 2 * BITS_AB;
    localparam int SW   = 2 * BITS_AB + $clog2(DIM) + BITS_C + 1;
    localparam int CW   = $clog2(3 * DIM);
    localparam int RW   = $clog2(DIM);

    localparam logic [CW-1:0] CNT_LAST = CW'(3 * DIM - 3);
    localparam logic [CW-1:0] CNT_ROWS = CW'(DIM);
    localparam logic [8:0]    NA       = 9'(DIM * WA);
    localparam logic [8:0]    NC       = 9'(DIM * WC);

    localparam logic signed [SW-1:0] C_MAX = {{(SW-BITS_C+1){1'b0}}, {(BITS_C-1){1'b1}}};
    localparam logic signed [SW-1:0] C_MIN = {{(SW-BITS_C+1){1'b1}}, {(BITS_C-1){1'b0}}};

    function automatic logic signed [SW-1:0] sx_c(input logic [BITS_C-1:0] v);
        return {{(SW-BITS_C){v[BITS_C-1]}}, v};
    endfunction

    function automatic logic signed [SW-1:0] mul_ab(input logic [BITS_AB-1:0] a,
                                                    input logic [BITS_AB-1:0] b);
        logic signed [PW-1:0] ae;
        logic signed [PW-1:0] be;
        logic signed [PW-1:0] p;
        ae = {{BITS_AB{a[BITS_AB-1]}}, a};
        be = {{BITS_AB{b[BITS_AB-1]}}, b};
        p  = ae * be;
        return {{(SW-PW){p[PW-1]}}, p};
    endfunction

    logic [RA-1:0]    r_a   [DIM];
    logic [RA-1:0]    r_b   [DIM];
    logic [RC-1:0]    r_c   [DIM];
    logic [RC-1:0]    r_res [DIM];
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [2:0]       r_mode;
    logic [CW-1:0]    r_cnt;
    logic [DATAW-1:0] r_dout;
    logic             r_rvalid;
    logic             r_irq;

    logic [1:0]       w_region;
    logic [7:0]       w_off;
    logic             w_hi_ok;
    logic             w_is_a;
    logic             w_is_b;
    logic             w_is_c;
    logic             w_is_ctl;
    logic             w_is_stat;
    logic             w_wmapped;
    logic [RW-1:0]    w_a_row;
    logic [RW-1:0]    w_c_row;
    logic [7:0]       w_a_wd;
    logic [7:0]       w_c_wd;
    logic [DATAW-1:0] w_rdata;
    logic [RW-1:0]    w_row;
    logic             w_acc;
    logic [BITS_C-1:0] w_col_res [DIM];

    // Upper address bits must be zero so aliases of the tile are not decoded.
    assign w_region  = addr[9:8];
    assign w_off     = addr[7:0];
    assign w_hi_ok   = (addr[ADDRW-1:10] == '0);
    assign w_is_a    = w_hi_ok && (w_region == 2'b01) && ({1'b0, w_off} < NA);
    assign w_is_b    = w_hi_ok && (w_region == 2'b10) && ({1'b0, w_off} < NA);
    assign w_is_c    = w_hi_ok && (w_region == 2'b11) && ({1'b0, w_off} < NC);
    assign w_is_ctl  = w_hi_ok && (w_region == 2'b00) && (w_off == 8'd0);
    assign w_is_stat = w_hi_ok && (w_region == 2'b00) && (w_off == 8'd1);
    assign w_wmapped = w_is_a || w_is_b || w_is_c || w_is_ctl;

    always_comb begin
        w_a_row = RW'(int'(w_off) / WA);
        w_a_wd  = 8'(int'(w_off) % WA);
        w_c_row = RW'(int'(w_off) / WC);
        w_c_wd  = 8'(int'(w_off) % WC);
    end

    always_comb begin
        w_rdata = '0;
        if (w_is_stat) begin
            w_rdata[5:0] = {r_mode, r_err, r_done, r_busy};
        end else if (!r_busy) begin
            if (w_is_a)
                w_rdata = r_a[w_a_row][w_a_wd*DATAW +: DATAW];
            else if (w_is_b)
                w_rdata = r_b[w_a_row][w_a_wd*DATAW +: DATAW];
            else if (w_is_c)
                w_rdata = r_c[w_c_row][w_c_wd*DATAW +: DATAW];
        end
    end

    // Row r of the result is formed in job cycle r; CLRC leaves C zeroed, so ACC is harmless then.
    assign w_row = r_cnt[RW-1:0];
    assign w_acc = r_mode[1] | r_mode[0];

    generate
        for (genvar gi = 0; gi < DIM; gi++) begin : g_col
            logic signed [SW-1:0] w_sum;
            logic [BITS_C-1:0]    w_red;
            always_comb begin
                w_sum = w_acc ? sx_c(r_c[w_row][gi*BITS_C +: BITS_C]) : '0;
                for (int k = 0; k < DIM; k++)
                    w_sum = w_sum + mul_ab(r_a[w_row][k*BITS_AB +: BITS_AB],
                                           r_b[k][gi*BITS_AB +: BITS_AB]);
                if (r_mode[2] && (w_sum > C_MAX))
                    w_red = C_MAX[BITS_C-1:0];
                else if (r_mode[2] && (w_sum < C_MIN))
                    w_red = C_MIN[BITS_C-1:0];
                else
                    w_red = w_sum[BITS_C-1:0];
            end
            assign w_col_res[gi] = w_red;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIM; i++) begin
                r_a[i]   <= '0;
                r_b[i]   <= '0;
                r_c[i]   <= '0;
                r_res[i] <= '0;
            end
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_mode   <= '0;
            r_cnt    <= '0;
            r_dout   <= '0;
            r_rvalid <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_irq    <= 1'b0;

            if (req && !r_w) begin
                r_rvalid <= 1'b1;
                r_dout   <= w_rdata;
                if (w_is_stat) begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                end
            end

            if (req && r_w && w_wmapped) begin
                if (r_busy) begin
                    r_err <= 1'b1;
                end else if (w_is_a) begin
                    r_a[w_a_row][w_a_wd*DATAW +: DATAW] <= dataIn;
                end else if (w_is_b) begin
                    r_b[w_a_row][w_a_wd*DATAW +: DATAW] <= dataIn;
                end else if (w_is_c) begin
                    r_c[w_c_row][w_c_wd*DATAW +: DATAW] <= dataIn;
                end else begin
                    r_mode <= {dataIn[3], dataIn[1], dataIn[2]};
                    if (dataIn[2]) begin
                        for (int i = 0; i < DIM; i++)
                            r_c[i] <= '0;
                    end
                    if (dataIn[0]) begin
                        r_busy <= 1'b1;
                        r_cnt  <= '0;
                    end
                end
            end

            // Completion wins over a same-cycle STATUS read so DONE is never lost.
            if (r_busy) begin
                if (r_cnt < CNT_ROWS) begin
                    for (int j = 0; j < DIM; j++)
                        r_res[w_row][j*BITS_C +: BITS_C] <= w_col_res[j];
                end
                if (r_cnt == CNT_LAST) begin
                    for (int i = 0; i < DIM; i++)
                        r_c[i] <= r_res[i];
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_irq  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign dataOut = r_dout;
    assign rvalid  = r_rvalid;
    assign irq     = r_irq;

endmodule

// File: tb/tb_tpuv2.sv
// Scoreboard bench for tpuv2: reads push expected words, a negedge monitor pops and compares.
// Two instances share the bus wires: DIM=8/DATAW=64 (sel 0) and DIM=4/DATAW=32 (sel 1).
module tb_tpuv2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req8 = 1'b0;
    logic        req4 = 1'b0;
    logic        r_w = 1'b0;
    logic [15:0] addr = '0;
    logic [63:0] din = '0;
    logic [63:0] dout8;
    logic [31:0] dout4;
    logic        rvalid8, rvalid4, irq8, irq4;

    always #5 clk = ~clk;

    tpuv2 u_dut8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .r_w(r_w), .addr(addr),
        .dataIn(din), .dataOut(dout8), .rvalid(rvalid8), .irq(irq8)
    );

    tpuv2 #(.DIM(4), .DATAW(32)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .r_w(r_w), .addr(addr),
        .dataIn(din[31:0]), .dataOut(dout4), .rvalid(rvalid4), .irq(irq4)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];
    string       tag_q[$];
    int          cyc = 0;
    int          irq_cnt[2];
    int          irq_cyc[2];
    int          ma[16][16];
    int          mb[16][16];
    int          mc[16][16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%h", tag, got);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (irq8) begin irq_cnt[0]++; irq_cyc[0] = cyc; end
        if (irq4) begin irq_cnt[1]++; irq_cyc[1] = cyc; end
        if (rvalid8 || rvalid4) begin
            if (exp_q.size() == 0) begin
                check("unexpected rvalid", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                string       t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check(t, rvalid8 ? dout8 : {32'b0, dout4}, e);
            end
        end
    end

    task automatic bus_wr(input int sel, input logic [15:0] a, input logic [63:0] d);
        if (sel == 0) req8 = 1'b1; else req4 = 1'b1;
        r_w = 1'b1; addr = a; din = d;
        @(negedge clk);
        req8 = 1'b0; req4 = 1'b0; r_w = 1'b0;
    endtask

    task automatic bus_rd(input int sel, input logic [15:0] a, input logic [63:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        if (sel == 0) req8 = 1'b1; else req4 = 1'b1;
        r_w = 1'b0; addr = a;
        @(negedge clk);
        req8 = 1'b0; req4 = 1'b0;
    endtask

    function automatic logic [63:0] pack(input int which, input int r, input int first,
                                         input int cnt, input int bits);
        logic [63:0] w, e;
        int v;
        w = '0;
        for (int i = 0; i < cnt; i++) begin
            v = (which == 0) ? ma[r][first+i] : (which == 1) ? mb[r][first+i] : mc[r][first+i];
            e = 64'(v) & ((64'd1 << bits) - 64'd1);
            w = w | (e << (i * bits));
        end
        return w;
    endfunction

    task automatic load_ab(input int sel, input int n, input int dw);
        int wa, epw;
        wa = n * 8 / dw; epw = dw / 8;
        for (int r = 0; r < n; r++)
            for (int w = 0; w < wa; w++) begin
                bus_wr(sel, 16'h100 + 16'(r * wa + w), pack(0, r, w * epw, epw, 8));
                bus_wr(sel, 16'h200 + 16'(r * wa + w), pack(1, r, w * epw, epw, 8));
            end
    endtask

    task automatic load_c(input int sel, input int n, input int dw);
        int wc, epw;
        wc = n * 16 / dw; epw = dw / 16;
        for (int r = 0; r < n; r++)
            for (int w = 0; w < wc; w++)
                bus_wr(sel, 16'h300 + 16'(r * wc + w), pack(2, r, w * epw, epw, 16));
    endtask

    task automatic check_c(input int sel, input int n, input int dw, input string tag);
        int wc, epw;
        wc = n * 16 / dw; epw = dw / 16;
        for (int r = 0; r < n; r++)
            for (int w = 0; w < wc; w++)
                bus_rd(sel, 16'h300 + 16'(r * wc + w), pack(2, r, w * epw, epw, 16),
                       $sformatf("%s C[%0d].%0d", tag, r, w));
    endtask

    task automatic model_job(input int n, input logic [3:0] ctrl);
        longint s;
        if (ctrl[2]) foreach (mc[i, j]) mc[i][j] = 0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                s = (ctrl[1] || ctrl[2]) ? longint'(mc[i][j]) : 0;
                for (int k = 0; k < n; k++) s += longint'(ma[i][k] * mb[k][j]);
                if (ctrl[3]) begin
                    if (s > 32767) s = 32767;
                    if (s < -32768) s = -32768;
                end else begin
                    s = s & 64'hFFFF;
                    if (s >= 32768) s -= 65536;
                end
                mc[i][j] = int'(s);
            end
    endtask

    // act: 0 plain job, 1 illegal accesses while busy, 2 unmapped write while busy
    task automatic job(input int sel, input int n, input logic [3:0] ctrl, input int act);
        int t0, ic0, lat, k, wa;
        logic [63:0] m;
        lat = 3 * n - 2;
        wa  = n * 8 / ((sel == 0) ? 64 : 32);
        m   = 64'({ctrl[3], ctrl[1], ctrl[2]}) << 3;
        ic0 = irq_cnt[sel];
        bus_wr(sel, 16'h000, 64'(ctrl));
        t0 = cyc;
        bus_rd(sel, 16'h001, m | 64'h1, "status busy");
        k = 1;
        if (act == 1) begin
            bus_wr(sel, 16'h100, '1);
            bus_wr(sel, 16'h000, 64'h1);
            bus_rd(sel, 16'h100, 64'h0, "A busy read");
            bus_rd(sel, 16'h200, 64'h0, "B busy read");
            bus_rd(sel, 16'h300, 64'h0, "C busy read");
            k = 6;
        end else if (act == 2) begin
            bus_wr(sel, 16'h100 + 16'(n * wa), '1);
            k = 2;
        end
        repeat (lat - 1 - k) @(negedge clk);
        bus_rd(sel, 16'h001, m | 64'h1 | ((act == 1) ? 64'h4 : 64'h0), "status at completion");
        @(negedge clk);
        check("irq count", 64'(irq_cnt[sel] - ic0), 64'd1);
        check("irq latency", 64'(irq_cyc[sel] - t0), 64'(lat));
        bus_rd(sel, 16'h001, m | 64'h2, "status done");
        bus_rd(sel, 16'h001, m, "status cleared");
        model_job(n, ctrl);
    endtask

    initial begin
        int ic;
        foreach (ma[i, j]) begin ma[i][j] = 0; mb[i][j] = 0; mc[i][j] = 0; end
        irq_cnt[0] = 0; irq_cnt[1] = 0; irq_cyc[0] = 0; irq_cyc[1] = 0;
        repeat (3) @(negedge clk);
        check("reset dataOut", dout8, 64'h0);
        check("reset rvalid", 64'(rvalid8), 64'h0);
        check("reset irq", 64'(irq8), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        bus_rd(0, 16'h001, 64'h0, "reset status");
        bus_rd(0, 16'h100, 64'h0, "reset A[0]");
        bus_rd(0, 16'h30F, 64'h0, "reset C[7].1");

        // Identity A, ramp B: C = B, then accumulate to 2B, then clear
        foreach (ma[i, j]) begin ma[i][j] = (i == j) ? 1 : 0; mb[i][j] = i * 8 + j; end
        load_ab(0, 8, 64);
        job(0, 8, 4'b0001, 0);
        check_c(0, 8, 64, "C=B");
        job(0, 8, 4'b0011, 2);
        check_c(0, 8, 64, "C=2B");
        bus_wr(0, 16'h000, 64'h4);
        model_job(0, 4'b0100);
        check_c(0, 8, 64, "CLRC");
        bus_rd(0, 16'h108, 64'h0, "unmapped A read");
        bus_rd(0, 16'h002, 64'h0, "unmapped ctl read");

        // Busy interlock: ignored writes, ERR, single irq, A unchanged
        job(0, 8, 4'b0001, 1);
        bus_rd(0, 16'h100, pack(0, 0, 0, 8, 8), "A[0] after busy write");
        check_c(0, 8, 64, "busy job");

        // Saturation and wrap with 127*127
        foreach (ma[i, j]) begin ma[i][j] = 127; mb[i][j] = 127; end
        load_ab(0, 8, 64);
        job(0, 8, 4'b1001, 0);
        check_c(0, 8, 64, "sat max");
        job(0, 8, 4'b0001, 0);
        check_c(0, 8, 64, "wrap");

        // Negative saturation, accumulate into preloaded -1, CLRC+START
        foreach (ma[i, j]) begin ma[i][j] = -128; mb[i][j] = 127; end
        load_ab(0, 8, 64);
        job(0, 8, 4'b1001, 0);
        check_c(0, 8, 64, "sat min");
        foreach (mc[i, j]) mc[i][j] = -1;
        load_c(0, 8, 64);
        job(0, 8, 4'b1011, 0);
        check_c(0, 8, 64, "acc sat min");
        job(0, 8, 4'b0101, 0);
        check_c(0, 8, 64, "clrc+start");

        // Reset in the middle of a job
        bus_wr(0, 16'h000, 64'h1);
        repeat (9) @(negedge clk);
        ic = irq_cnt[0];
        rst_n = 1'b0;
        @(negedge clk);
        check("rst mid-job rvalid", 64'(rvalid8), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("no irq after abort", 64'(irq_cnt[0] - ic), 64'd0);
        foreach (ma[i, j]) begin ma[i][j] = 0; mb[i][j] = 0; mc[i][j] = 0; end
        bus_rd(0, 16'h001, 64'h0, "status after abort");
        bus_rd(0, 16'h100, 64'h0, "A[0] after abort");
        check_c(0, 8, 64, "abort");

        // Small configuration: DIM=4, DATAW=32
        foreach (ma[i, j]) begin
            ma[i][j] = int'($urandom_range(0, 255)) - 128;
            mb[i][j] = int'($urandom_range(0, 255)) - 128;
        end
        load_ab(1, 4, 32);
        job(1, 4, 4'b0001, 0);
        check_c(1, 4, 32, "d4 mul");
        job(1, 4, 4'b1011, 0);
        check_c(1, 4, 32, "d4 acc sat");
        bus_rd(1, 16'h308, 64'h0, "d4 unmapped C");

        repeat (3) @(negedge clk);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
